// File: rtl/fifo_burst_reader.sv
// ============================================================================
// Module   : fifo_burst_reader
// Brief    : Show-ahead FIFO consumer re-issuing words as a valid/ready stream
//            with last_o every BURST_LEN beats and a completed-burst counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_burst_reader #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_data_i,
  output logic             fifo_rd_en_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o,
  output logic [CNT_W-1:0] burst_cnt_o
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] c_beat_last = BEAT_W'(BURST_LEN - 1);

  logic [1:0]        r_cnt;
  logic [WIDTH-1:0]  r_head;
  logic [WIDTH-1:0]  r_tail;
  logic [BEAT_W-1:0] r_beat;
  logic [CNT_W-1:0]  r_bursts;
  logic              w_pop;
  logic              w_out;

  // Pop decision looks only at registered occupancy, never at ready_i.
  assign w_pop = !rst_i && enable_i && !fifo_empty_i && (r_cnt != 2'd2);
  assign w_out = (r_cnt != 2'd0) && ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= 2'd0;
    end else if (w_pop && !w_out) begin
      r_cnt <= r_cnt + 2'd1;
    end else if (w_out && !w_pop) begin
      r_cnt <= r_cnt - 2'd1;
    end
  end

  // Data storage carries no reset; contents are meaningless while r_cnt is 0.
  always_ff @(posedge clk_i) begin
    if (w_pop && ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_out))) begin
      r_head <= fifo_data_i;
    end else if (w_out && (r_cnt == 2'd2)) begin
      r_head <= r_tail;
    end
    if (w_pop && (r_cnt == 2'd1) && !w_out) begin
      r_tail <= fifo_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_beat   <= '0;
      r_bursts <= '0;
    end else if (w_out) begin
      if (r_beat == c_beat_last) begin
        r_beat   <= '0;
        r_bursts <= r_bursts + CNT_W'(1);
      end else begin
        r_beat <= r_beat + BEAT_W'(1);
      end
    end
  end

  assign fifo_rd_en_o = w_pop;
  assign valid_o      = (r_cnt != 2'd0);
  assign data_o       = r_head;
  assign last_o       = valid_o && (r_beat == c_beat_last);
  assign burst_cnt_o  = r_bursts;

endmodule

`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
// ============================================================================
// Module   : tb_fifo_burst_reader
// Brief    : Scoreboard bench for fifo_burst_reader with a show-ahead FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_burst_reader;

  localparam int WIDTH     = 8;
  localparam int BURST_LEN = 4;
  localparam int CNT_W     = 2;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             l;
  } exp_t;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             enable_i = 1'b1;
  logic             fifo_empty_i = 1'b1;
  logic [WIDTH-1:0] fifo_data_i = '0;
  logic             fifo_rd_en_o;
  logic             valid_o;
  logic             ready_i = 1'b1;
  logic [WIDTH-1:0] data_o;
  logic             last_o;
  logic [CNT_W-1:0] burst_cnt_o;

  fifo_burst_reader #(
    .WIDTH     (WIDTH),
    .BURST_LEN (BURST_LEN),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .data_o       (data_o),
    .last_o       (last_o),
    .burst_cnt_o  (burst_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  logic [WIDTH-1:0] src_q[$];
  exp_t             exp_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               push_idx = 0;
  int               out_idx  = 0;
  logic             pop_seen = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Monitor: samples on the falling edge, i.e. the state that the next rising edge commits.
  always @(negedge clk_i) begin
    pop_seen = fifo_rd_en_o;
    if (rst_i) begin
      exp_q.delete();
      out_idx = 0;
    end else begin
      if (fifo_rd_en_o) chk("rd_en_while_empty", {31'd0, fifo_empty_i}, 32'd0);
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {24'd0, data_o}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("beat_data", {24'd0, data_o}, {24'd0, e.d});
          chk("beat_last", {31'd0, last_o}, {31'd0, e.l});
          chk("beat_burst_cnt", {30'd0, burst_cnt_o}, (out_idx / BURST_LEN) % (1 << CNT_W));
        end
        out_idx++;
      end
    end
  end

  task automatic refresh();
    fifo_empty_i = (src_q.size() == 0);
    fifo_data_i  = (src_q.size() != 0) ? src_q[0] : '0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (pop_seen && src_q.size() != 0) src_q.delete(0);
    refresh();
  endtask

  task automatic push(input logic [WIDTH-1:0] w);
    exp_t e;
    e.d = w;
    e.l = ((push_idx % BURST_LEN) == BURST_LEN - 1);
    src_q.push_back(w);
    exp_q.push_back(e);
    push_idx++;
    refresh();
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0 && !valid_o) return;
      tick();
    end
    chk("drain_timeout", exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    src_q.delete();
    push_idx = 0;
    refresh();
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_pushed;
    int n_iter;
    // Reset state
    #1;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_last", {31'd0, last_o}, 32'd0);
    chk("rst_rd_en", {31'd0, fifo_rd_en_o}, 32'd0);
    chk("rst_burst_cnt", {30'd0, burst_cnt_o}, 32'd0);
    do_reset();

    // Streaming without backpressure: one word per cycle after a 1-cycle latency
    ready_i = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    chk("latency_valid_c0", {31'd0, valid_o}, 32'd0);
    tick();
    chk("latency_valid_c1", {31'd0, valid_o}, 32'd1);
    chk("latency_data_c1", {24'd0, data_o}, 32'h10);
    for (int i = 0; i < 8; i++) begin
      chk("stream_valid", {31'd0, valid_o}, 32'd1);
      tick();
    end
    chk("stream_done", exp_q.size(), 32'd0);
    chk("stream_valid_low", {31'd0, valid_o}, 32'd0);
    chk("stream_burst_cnt", {30'd0, burst_cnt_o}, 32'd2);

    // Backpressure: only two pops, head held
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h20 + 8'(i));
    for (int i = 0; i < 4; i++) tick();
    chk("bp_rd_en", {31'd0, fifo_rd_en_o}, 32'd0);
    chk("bp_valid", {31'd0, valid_o}, 32'd1);
    chk("bp_data", {24'd0, data_o}, 32'h20);
    chk("bp_pops", src_q.size(), 32'd3);
    ready_i = 1'b1;
    wait_drain(50);

    // Random ready and random arrivals
    n_pushed = 0;
    n_iter   = 0;
    while ((n_pushed < 1000 || exp_q.size() != 0 || valid_o) && n_iter < 20000) begin
      ready_i = 1'($urandom_range(0, 1));
      if (n_pushed < 1000 && $urandom_range(0, 1) == 1) begin
        push(WIDTH'($urandom));
        n_pushed++;
      end
      tick();
      n_iter++;
    end
    chk("random_complete", exp_q.size() + (1000 - n_pushed), 32'd0);
    ready_i = 1'b1;
    wait_drain(50);

    // Enable gap after two beats; burst continues afterwards
    do_reset();
    push(8'h40);
    push(8'h41);
    wait_drain(20);
    ready_i = 1'b0;
    push(8'h42);
    push(8'h43);
    tick();
    tick();
    tick();
    enable_i = 1'b0;
    push(8'h44);
    push(8'h45);
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("en_gap_rd_en", {31'd0, fifo_rd_en_o}, 32'd0);
    chk("en_gap_valid", {31'd0, valid_o}, 32'd0);
    chk("en_gap_src_left", src_q.size(), 32'd2);
    chk("en_gap_burst_cnt", {30'd0, burst_cnt_o}, 32'd1);
    enable_i = 1'b1;
    wait_drain(20);

    // Counter wrap with CNT_W=2: five bursts read back as 1
    do_reset();
    for (int i = 0; i < 20; i++) push(8'h50 + 8'(i));
    wait_drain(60);
    chk("wrap_burst_cnt", {30'd0, burst_cnt_o}, 32'd1);

    // Asynchronous reset with two buffered words on the last beat
    for (int i = 0; i < 3; i++) push(8'h60 + 8'(i));
    wait_drain(20);
    ready_i = 1'b0;
    push(8'h63);
    push(8'h64);
    tick();
    tick();
    tick();
    chk("pre_rst_valid", {31'd0, valid_o}, 32'd1);
    chk("pre_rst_last", {31'd0, last_o}, 32'd1);
    chk("pre_rst_data", {24'd0, data_o}, 32'h63);
    #2;
    rst_i = 1'b1;
    src_q.delete();
    push_idx = 0;
    refresh();
    #1;
    chk("arst_valid", {31'd0, valid_o}, 32'd0);
    chk("arst_last", {31'd0, last_o}, 32'd0);
    chk("arst_rd_en", {31'd0, fifo_rd_en_o}, 32'd0);
    chk("arst_burst_cnt", {30'd0, burst_cnt_o}, 32'd0);
    tick();
    tick();
    rst_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) push(8'h70 + 8'(i));
    wait_drain(20);
    chk("post_rst_burst_cnt", {30'd0, burst_cnt_o}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
